// File: rtl/fifo_read_arbiter_if.sv
// Read-domain bundle between the FIFO read port, the consumers and fifo_read_arbiter.
// The arbiter uses the master modport. The environment (FIFO and consumers) uses slave.
interface fifo_read_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]    req;
  logic                  empty;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  r_en;
  logic [NUM_REQ-1:0]    gnt;
  logic [DATA_WIDTH-1:0] dout;
  logic [NUM_REQ-1:0]    dvalid;
  logic [NUM_REQ-1:0]    dready;
  logic                  busy;

  modport master (
    input  req, empty, rdata, dready,
    output r_en, gnt, dout, dvalid, busy
  );

  modport slave (
    output req, empty, rdata, dready,
    input  r_en, gnt, dout, dvalid, busy
  );
endinterface

// File: rtl/fifo_read_arbiter.sv
// Round-robin sequencer that shares the FIFO read port among NUM_REQ consumers in the rclk domain.
// Define RD_ARB_STATS_EN to add saturating per-consumer served-word counters on served_cnt.
module fifo_read_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
`ifdef RD_ARB_STATS_EN
  , parameter int CNT_W    = 16
`endif
) (
  input  logic                     rclk,
  input  logic                     rrst_n,
  fifo_read_arbiter_if.master      bus
`ifdef RD_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0] served_cnt
`endif
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int BEAT_W = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {IDLE, READ, LOAD, DELIVER} state_t;

  state_t                state_reg;
  logic [NUM_REQ-1:0]    gnt_reg;
  logic [NUM_REQ-1:0]    dvalid_reg;
  logic [DATA_WIDTH-1:0] dout_reg;
  logic [IDX_W-1:0]      rr_ptr_reg;
  logic [BEAT_W-1:0]     beat_reg;
  logic [BEAT_W-1:0]     beat_next;
  logic [IDX_W-1:0]      win_idx_next;
  logic                  win_found;
  logic                  req_g;
  logic                  handshake;
  logic                  burst_done;

  assign req_g      = |(bus.req & gnt_reg);
  assign handshake  = |(dvalid_reg & bus.dready);
  assign beat_next  = beat_reg + BEAT_W'(1);
  assign burst_done = (beat_next == BEAT_W'(BURST_LEN));

  // The search starts one past the last winner, so the previous owner is considered last.
  always_comb begin
    int               pos;
    logic [IDX_W-1:0] idx;
    pos          = 0;
    idx          = '0;
    win_idx_next = '0;
    win_found    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = (int'(rr_ptr_reg) + k) % NUM_REQ;
      idx = IDX_W'(pos);
      if (!win_found && bus.req[idx]) begin
        win_found    = 1'b1;
        win_idx_next = idx;
      end
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_reg  <= IDLE;
      gnt_reg    <= '0;
      dvalid_reg <= '0;
      dout_reg   <= '0;
      beat_reg   <= '0;
      rr_ptr_reg <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            gnt_reg    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_next;
            rr_ptr_reg <= win_idx_next;
            beat_reg   <= '0;
            state_reg  <= READ;
          end
        end
        READ: begin
          // A withdrawn request takes priority over an available word.
          if (!req_g) begin
            gnt_reg   <= '0;
            state_reg <= IDLE;
          end else if (!bus.empty) begin
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          dout_reg   <= bus.rdata;
          dvalid_reg <= gnt_reg;
          state_reg  <= DELIVER;
        end
        DELIVER: begin
          // dvalid stays up until accepted, even if the consumer drops req meanwhile.
          if (handshake) begin
            dvalid_reg <= '0;
            beat_reg   <= beat_next;
            if (burst_done || !req_g) begin
              gnt_reg   <= '0;
              state_reg <= IDLE;
            end else begin
              state_reg <= READ;
            end
          end
        end
        default: begin
          gnt_reg    <= '0;
          dvalid_reg <= '0;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

  assign bus.r_en   = (state_reg == READ) & ~bus.empty & req_g;
  assign bus.gnt    = gnt_reg;
  assign bus.dvalid = dvalid_reg;
  assign bus.dout   = dout_reg;
  assign bus.busy   = (state_reg != IDLE);

`ifdef RD_ARB_STATS_EN
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_stats
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
          cnt_reg <= '0;
        end else if (dvalid_reg[gi] && bus.dready[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
      assign served_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
    end
  endgenerate
`endif

endmodule
